// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable instruction memory, program counter and a valid/stall issue handshake.
// Define FETCH_PERF_COUNTERS_EN to add the fetched_count_out / stall_cycles_out performance counters.
module instruction_fetch_unit #(
  parameter int INSTR_WIDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter int PC_WIDTH = $clog2(MEM_DEPTH),
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   load_enable_in,
  input  logic [PC_WIDTH-1:0]    load_address_in,
  input  logic [INSTR_WIDTH-1:0] load_data_in,
  input  logic                   run_in,
  input  logic                   stall_in,
  input  logic                   redirect_valid_in,
  input  logic [PC_WIDTH-1:0]    redirect_pc_in,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   instruction_valid_out,
  output logic [PC_WIDTH-1:0]    pc_out,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [15:0]            fetched_count_out,
  output logic [15:0]            stall_cycles_out,
`endif
  output logic                   halted_out
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  state_t                state, state_next;
  logic [PC_WIDTH-1:0]   pc, pc_next;
  logic                  valid_next;
  logic                  halted_next;
  logic                  capture;
  logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];

  // Memory is deliberately left out of reset so a program survives a reset.
  always_ff @(posedge clock_in) begin
    if (load_enable_in) begin
      mem[load_address_in] <= load_data_in;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    valid_next  = instruction_valid_out;
    halted_next = halted_out;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (run_in) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect_valid_in) begin
          pc_next = redirect_pc_in;
        end else begin
          capture    = 1'b1;
          valid_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // A redirect drops the presented instruction even if downstream takes it.
        if (redirect_valid_in) begin
          pc_next    = redirect_pc_in;
          valid_next = 1'b0;
          state_next = FETCH;
        end else if (!stall_in) begin
          valid_next = 1'b0;
          if (instruction_out == HALT_WORD) begin
            halted_next = 1'b1;
            state_next  = HALTED;
          end else begin
            pc_next    = pc + 1'b1;
            state_next = FETCH;
          end
        end
      end
      HALTED: begin
        if (run_in) begin
          halted_next = 1'b0;
          pc_next     = '0;
          state_next  = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state                 <= IDLE;
      pc                    <= '0;
      instruction_out       <= '0;
      instruction_valid_out <= 1'b0;
      halted_out            <= 1'b0;
    end else begin
      state                 <= state_next;
      pc                    <= pc_next;
      instruction_valid_out <= valid_next;
      halted_out            <= halted_next;
      if (capture) begin
        instruction_out <= mem[pc];
      end
    end
  end

  assign pc_out = pc;

`ifdef FETCH_PERF_COUNTERS_EN
  logic count_start, count_accept, count_stall;

  assign count_start  = ((state == IDLE) || (state == HALTED)) && run_in;
  assign count_accept = (state == ISSUE) && !redirect_valid_in && !stall_in;
  assign count_stall  = (state == ISSUE) && !redirect_valid_in && stall_in;

  // Saturating counters, restarted whenever a new run begins.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      fetched_count_out <= '0;
      stall_cycles_out  <= '0;
    end else if (count_start) begin
      fetched_count_out <= '0;
      stall_cycles_out  <= '0;
    end else begin
      if (count_accept && (fetched_count_out != 16'hFFFF)) begin
        fetched_count_out <= fetched_count_out + 16'd1;
      end
      if (count_stall && (stall_cycles_out != 16'hFFFF)) begin
        stall_cycles_out <= stall_cycles_out + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios then randomized traffic against a behavioural model.
// Counter outputs are checked when FETCH_PERF_COUNTERS_EN is defined.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 256;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        load_enable_in;
  logic [7:0]  load_address_in;
  logic [31:0] load_data_in;
  logic        run_in;
  logic        stall_in;
  logic        redirect_valid_in;
  logic [7:0]  redirect_pc_in;
  logic [31:0] instruction_out;
  logic        instruction_valid_out;
  logic [7:0]  pc_out;
  logic        halted_out;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] fetched_count_out;
  logic [15:0] stall_cycles_out;
`endif

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Behavioural model: program memory, whether a fetch run is in progress, and what is presented.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_running;
  bit          ref_presenting;
  bit          ref_halted;
  int          ref_pc;
  logic [31:0] ref_instr;
  int          ref_fetched;
  int          ref_stalls;

  instruction_fetch_unit dut (
    .clock_in              (clock_in),
    .reset_in              (reset_in),
    .load_enable_in        (load_enable_in),
    .load_address_in       (load_address_in),
    .load_data_in          (load_data_in),
    .run_in                (run_in),
    .stall_in              (stall_in),
    .redirect_valid_in     (redirect_valid_in),
    .redirect_pc_in        (redirect_pc_in),
    .instruction_out       (instruction_out),
    .instruction_valid_out (instruction_valid_out),
    .pc_out                (pc_out),
`ifdef FETCH_PERF_COUNTERS_EN
    .fetched_count_out     (fetched_count_out),
    .stall_cycles_out      (stall_cycles_out),
`endif
    .halted_out            (halted_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    ref_running    = 1'b0;
    ref_presenting = 1'b0;
    ref_halted     = 1'b0;
    ref_pc         = 0;
    ref_instr      = 32'h0;
    ref_fetched    = 0;
    ref_stalls     = 0;
  endtask

  // One clock of the model, using the inputs currently driven.
  task automatic model_cycle();
    logic [31:0] old_word;
    old_word = ref_mem[ref_pc];
    if (ref_presenting) begin
      if (redirect_valid_in) begin
        ref_pc         = int'(redirect_pc_in);
        ref_presenting = 1'b0;
      end else if (!stall_in) begin
        ref_presenting = 1'b0;
        if (ref_fetched < 65535) ref_fetched++;
        if (ref_instr == HALT) begin
          ref_halted  = 1'b1;
          ref_running = 1'b0;
        end else begin
          ref_pc = (ref_pc + 1) % DEPTH;
        end
      end else if (ref_stalls < 65535) begin
        ref_stalls++;
      end
    end else if (ref_running) begin
      if (redirect_valid_in) begin
        ref_pc = int'(redirect_pc_in);
      end else begin
        ref_instr      = old_word;
        ref_presenting = 1'b1;
      end
    end else if (run_in) begin
      ref_running = 1'b1;
      ref_halted  = 1'b0;
      ref_pc      = 0;
      ref_fetched = 0;
      ref_stalls  = 0;
    end
    if (load_enable_in) ref_mem[load_address_in] = load_data_in;
  endtask

  task automatic check_output(input string tag);
    check({tag, "_valid"}, {31'b0, instruction_valid_out}, {31'b0, ref_presenting});
    check({tag, "_pc"}, {24'b0, pc_out}, ref_pc[31:0]);
    check({tag, "_halted"}, {31'b0, halted_out}, {31'b0, ref_halted});
    check({tag, "_instr"}, instruction_out, ref_instr);
`ifdef FETCH_PERF_COUNTERS_EN
    check({tag, "_fetched"}, {16'b0, fetched_count_out}, ref_fetched[31:0]);
    check({tag, "_stalls"}, {16'b0, stall_cycles_out}, ref_stalls[31:0]);
`endif
  endtask

  task automatic apply_stimulus(input bit ld, input logic [7:0] la, input logic [31:0] ldata,
                                input bit run, input bit stall, input bit redir,
                                input logic [7:0] rpc, input string tag);
    load_enable_in    = ld;
    load_address_in   = la;
    load_data_in      = ldata;
    run_in            = run;
    stall_in          = stall;
    redirect_valid_in = redir;
    redirect_pc_in    = rpc;
    @(posedge clock_in);
    model_cycle();
    #1;
    check_output(tag);
  endtask

  task automatic step(input bit run, input bit stall, input bit redir, input logic [7:0] rpc, input string tag);
    apply_stimulus(1'b0, 8'd0, 32'h0, run, stall, redir, rpc, tag);
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    apply_stimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0, 8'd0, "load");
  endtask

  initial begin
    reset_in          = 1'b1;
    load_enable_in    = 1'b0;
    load_address_in   = 8'd0;
    load_data_in      = 32'h0;
    run_in            = 1'b0;
    stall_in          = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = 8'd0;
    model_reset();
    #12;
    check_output("reset");
    @(negedge clock_in);
    reset_in = 1'b0;

    for (int i = 0; i < DEPTH; i++) load(8'(i), ($urandom_range(15) == 0) ? HALT : $urandom);

    // Two instructions then a halt, no stalls.
    load(8'd0, 32'h0000_0001);
    load(8'd1, 32'h0000_0002);
    load(8'd2, HALT);
    step(1'b1, 1'b0, 1'b0, 8'd0, "s1_run");
    for (int k = 2; k <= 9; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0, "s1");
      if (k == 2) check("s1_first_instr", instruction_out, 32'h0000_0001);
      if (k == 4) check("s1_second_pc", {24'b0, pc_out}, 32'd1);
      if (k == 6) check("s1_halt_instr", instruction_out, HALT);
      if (k == 7) check("s1_halted", {31'b0, halted_out}, 32'd1);
    end
    check("s1_final_valid", {31'b0, instruction_valid_out}, 32'd0);

    // Stall for three cycles while presenting pc 0.
    load(8'd0, 32'hA5A5_0003);
    load(8'd1, 32'h0000_1111);
    load(8'd40, 32'h1234_5678);
    load(8'd255, 32'h0000_0007);
    step(1'b1, 1'b0, 1'b0, 8'd0, "s2_run");
    step(1'b0, 1'b0, 1'b0, 8'd0, "s2_fetch");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'd0, "s2_stall");
      check("s2_hold_instr", instruction_out, 32'hA5A5_0003);
      check("s2_hold_pc", {24'b0, pc_out}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 8'd0, "s2_accept");
    check("s2_pc_advanced", {24'b0, pc_out}, 32'd1);

    // Redirect while presenting pc 1.
    step(1'b0, 1'b0, 1'b0, 8'd0, "s3_issue");
    step(1'b0, 1'b0, 1'b1, 8'd40, "s3_redirect");
    check("s3_dropped_valid", {31'b0, instruction_valid_out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0, "s3_fetch");
    check("s3_target_instr", instruction_out, 32'h1234_5678);
    check("s3_target_pc", {24'b0, pc_out}, 32'd40);

    // Top-of-memory wrap.
    step(1'b0, 1'b0, 1'b1, 8'd255, "s4_redirect");
    step(1'b0, 1'b0, 1'b0, 8'd0, "s4_fetch");
    check("s4_top_instr", instruction_out, 32'h0000_0007);
    step(1'b0, 1'b0, 1'b0, 8'd0, "s4_accept");
    check("s4_wrap_pc", {24'b0, pc_out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0, "s4_issue");

    // Asynchronous reset between clock edges while presenting.
    #3;
    reset_in = 1'b1;
    #1;
    model_reset();
    check_output("async_reset");
    @(negedge clock_in);
    reset_in = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'd0, "s5_run");
    step(1'b0, 1'b0, 1'b0, 8'd0, "s5_fetch");
    check("s5_retained", instruction_out, 32'hA5A5_0003);

    // Short program with two stall cycles on pc 1.
    load(8'd0, 32'h0000_0001);
    load(8'd1, 32'h0000_0002);
    load(8'd2, HALT);
    reset_in = 1'b1;
    #1;
    model_reset();
    reset_in = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'd0, "s6_run");
    step(1'b0, 1'b0, 1'b0, 8'd0, "s6");
    step(1'b0, 1'b0, 1'b0, 8'd0, "s6");
    step(1'b0, 1'b0, 1'b0, 8'd0, "s6");
    step(1'b0, 1'b1, 1'b0, 8'd0, "s6_stall");
    step(1'b0, 1'b1, 1'b0, 8'd0, "s6_stall");
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 8'd0, "s6");
    check("s6_halted", {31'b0, halted_out}, 32'd1);
`ifdef FETCH_PERF_COUNTERS_EN
    check("s6_fetched_count", {16'b0, fetched_count_out}, 32'd3);
    check("s6_stall_cycles", {16'b0, stall_cycles_out}, 32'd2);
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      apply_stimulus($urandom_range(3) == 0, 8'($urandom_range(255)),
                     ($urandom_range(15) == 0) ? HALT : $urandom,
                     $urandom_range(3) == 0, $urandom_range(2) == 0,
                     $urandom_range(5) == 0, 8'($urandom_range(255)), "rand");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
